// File: rtl/queue_arb_pkg.sv
// queue_arb_pkg: shared FSM state type and index-width helper for the queue drain arbiter
package queue_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set req bit scanning upward from last+1 with wrap; last has lowest priority
// req in: request vector; last in: previous grant index
// pick out: chosen index; pick_valid out: some request was set
module rr_priority_picker
  import queue_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  localparam int IDX_WIDTH = clog2(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [IDX_WIDTH-1:0]   last,
  output logic [IDX_WIDTH-1:0]   pick,
  output logic                   pick_valid
);
  logic [IDX_WIDTH-1:0] s;
  always_comb begin
    pick = '0;
    pick_valid = 1'b0;
    s = '0;
    for (int k = NUM_SOURCES; k >= 1; k--) begin
      s = IDX_WIDTH'((int'(last) + k) % NUM_SOURCES);
      if (req[s]) begin
        pick = s;
        pick_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/queue_drain_arbiter.sv
// queue_drain_arbiter: round-robin burst arbiter draining NUM_SOURCES queues into one downstream port
// clock/resetN: rising-edge clock, asynchronous active-low reset
// src_data/src_valid/src_enable in, src_back_pressure out: per-queue front item, non-empty, grant mask, pop inhibit
// out_data/out_valid out, out_back_pressure in: shared downstream port
// grant_onehot/busy out: current grant (zero when idle) and grant-state flag
module queue_drain_arbiter
  import queue_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN = 4,
  localparam int IDX_WIDTH = clog2(NUM_SOURCES)
) (
  input  logic                              clock,
  input  logic                              resetN,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SOURCES-1:0]            src_valid,
  output logic [NUM_SOURCES-1:0]            src_back_pressure,
  input  logic [NUM_SOURCES-1:0]            src_enable,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_back_pressure,
  output logic [NUM_SOURCES-1:0]            grant_onehot,
  output logic                              busy
);
  arb_state_t state, state_nxt;
  logic [IDX_WIDTH-1:0] grant, grant_nxt, last_grant, last_nxt, pick;
  logic [7:0] beat_count, beat_nxt;
  logic [NUM_SOURCES-1:0] req;
  logic pick_valid, in_grant, gnt_req, xfer, burst_end;
  assign req = src_valid & src_enable;
  assign in_grant = state == ARB_GRANT;
  assign gnt_req = req[grant];
  assign xfer = in_grant & gnt_req & ~out_back_pressure;
  assign burst_end = in_grant & (~gnt_req | (xfer & (beat_count == 8'(BURST_LEN - 1))));
  // while granted, the holder itself is the lowest-priority point for the same-cycle re-pick
  rr_priority_picker #(.NUM_SOURCES(NUM_SOURCES)) u_pick (
    .req(req),
    .last(in_grant ? grant : last_grant),
    .pick(pick),
    .pick_valid(pick_valid)
  );
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= ARB_IDLE;
      grant <= '0;
      last_grant <= IDX_WIDTH'(NUM_SOURCES - 1);
      beat_count <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last_grant <= last_nxt;
      beat_count <= beat_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt = last_grant;
    beat_nxt = beat_count;
    if (!in_grant || burst_end) begin
      state_nxt = pick_valid ? ARB_GRANT : ARB_IDLE;
      grant_nxt = pick_valid ? pick : grant;
      last_nxt = in_grant ? grant : last_grant;
      beat_nxt = '0;
    end else if (xfer) begin
      beat_nxt = beat_count + 8'd1;
    end
  end
  always_comb begin
    busy = in_grant;
    out_valid = in_grant & gnt_req;
    out_data = '0;
    src_back_pressure = '1;
    grant_onehot = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (in_grant && grant == IDX_WIDTH'(i)) begin
        out_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        src_back_pressure[i] = out_back_pressure | ~gnt_req;
        grant_onehot[i] = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_queue_drain_arbiter.sv
// tb_queue_drain_arbiter: scoreboard bench with queue models and a burst-order reference model
module tb_queue_drain_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;
  localparam int LIMIT = 3000;
  typedef struct {
    int src;
    logic [W-1:0] data;
  } exp_t;
  logic clock = 1'b0;
  logic resetN;
  logic [N*W-1:0] src_data;
  logic [N-1:0] src_valid, src_back_pressure, src_enable, grant_onehot;
  logic [W-1:0] out_data;
  logic out_valid, out_back_pressure, busy;
  logic [W-1:0] srcq [N][$];
  exp_t sb[$];
  int rd = 0;
  int tot = 0;
  int bad = 0;
  int mlast = N - 1;
  logic [N-1:0] pop = '0;
  logic chk_idle = 1'b0, chk_ov = 1'b0, exp_ov = 1'b0, chk_busy = 1'b0, exp_busy = 1'b0;
  logic tmo = 1'b0, fin_chk = 1'b0;
  logic [14:0] ovp, busyp;
  exp_t e;
  logic [N-1:0] want_gnt, want_pop, got_pop;
  logic xf;

  queue_drain_arbiter dut (
    .clock(clock),
    .resetN(resetN),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_back_pressure(src_back_pressure),
    .src_enable(src_enable),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_back_pressure(out_back_pressure),
    .grant_onehot(grant_onehot),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (chk_idle) begin
      tot++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || src_back_pressure !== '1 || grant_onehot !== '0 || out_data !== '0) begin
        bad++;
        $display("FAIL idle_outputs: got ov=%b busy=%b bp=%b gnt=%b data=%h, want ov=0 busy=0 bp=1111 gnt=0000 data=00",
                 out_valid, busy, src_back_pressure, grant_onehot, out_data);
      end
    end
    if (chk_ov) begin
      tot++;
      if (out_valid !== exp_ov) begin
        bad++;
        $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, exp_ov);
      end
    end
    if (chk_busy) begin
      tot++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy @%0t: got %b want %b", $time, busy, exp_busy);
      end
    end
    pop = '0;
    if (resetN) begin
      got_pop = src_valid & ~src_back_pressure;
      want_pop = '0;
      xf = out_valid && !out_back_pressure;
      if (rd < sb.size()) begin
        e = sb[rd];
        want_gnt = N'(1) << e.src;
      end else begin
        e.src = -1;
        e.data = '0;
        want_gnt = '0;
      end
      if (xf || (out_valid && rd < sb.size())) begin
        tot++;
        if (rd >= sb.size()) begin
          bad++;
          $display("FAIL unexpected_transfer @%0t: got data=%h gnt=%b, want no transfer", $time, out_data, grant_onehot);
        end else if (out_data !== e.data || grant_onehot !== want_gnt) begin
          bad++;
          $display("FAIL %s #%0d @%0t: got data=%h gnt=%b, want data=%h gnt=%b",
                   xf ? "transfer" : "stall_hold", rd, $time, out_data, grant_onehot, e.data, want_gnt);
        end
        if (xf && rd < sb.size()) begin
          want_pop = want_gnt;
          rd++;
        end
      end
      tot++;
      if (got_pop !== want_pop) begin
        bad++;
        $display("FAIL queue_pop @%0t: got %b want %b", $time, got_pop, want_pop);
      end
      pop = got_pop;
    end
    if (tmo) begin
      tot++;
      bad++;
      $display("FAIL drain_timeout: got %0d of %0d items after %0d cycles, want all", rd, sb.size(), LIMIT);
    end
    if (fin_chk) begin
      tot++;
      if (rd != sb.size()) begin
        bad++;
        $display("FAIL items_consumed: got %0d want %0d", rd, sb.size());
      end
    end
  end

  task automatic adv();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (pop[i]) void'(srcq[i].pop_front());
    chk_idle = 1'b0;
    chk_ov = 1'b0;
    chk_busy = 1'b0;
    tmo = 1'b0;
    fin_chk = 1'b0;
  endtask

  task automatic fin();
    for (int i = 0; i < N; i++) begin
      src_valid[i] = srcq[i].size() > 0;
      src_data[i*W +: W] = '0;
      if (srcq[i].size() > 0) src_data[i*W +: W] = srcq[i][0];
    end
    @(negedge clock);
    #1;
  endtask

  task automatic load(input int s, input int n);
    repeat (n) srcq[s].push_back(W'($urandom));
  endtask

  task automatic expect_item(input int s, input logic [W-1:0] d);
    exp_t x;
    x.src = s;
    x.data = d;
    sb.push_back(x);
  endtask

  // Whole-drain order from static queue contents: visit enabled non-empty queues round-robin
  // after the previous holder, taking min(BURST, remaining) items each visit.
  task automatic model(input logic [N-1:0] en);
    int cnt[N];
    int pos[N];
    int s, t;
    for (int i = 0; i < N; i++) begin
      cnt[i] = srcq[i].size();
      pos[i] = 0;
    end
    forever begin
      s = -1;
      for (int k = 1; k <= N && s < 0; k++) begin
        t = (mlast + k) % N;
        if (((en >> t) & 1) != 0 && cnt[t] > 0) s = t;
      end
      if (s < 0) break;
      for (int j = 0; j < B && cnt[s] > 0; j++) begin
        expect_item(s, srcq[s][pos[s]]);
        pos[s]++;
        cnt[s]--;
      end
      mlast = s;
    end
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while ((rd != sb.size() || busy) && n < LIMIT) begin
      adv();
      out_back_pressure = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      fin();
      n++;
    end
    if (n >= LIMIT) begin
      adv();
      tmo = 1'b1;
      fin();
    end
  endtask

  initial begin
    resetN = 1'b0;
    src_enable = '1;
    out_back_pressure = 1'b0;
    src_valid = '0;
    src_data = '0;
    repeat (2) begin adv(); chk_idle = 1'b1; fin(); end
    adv(); resetN = 1'b1; chk_idle = 1'b1; fin();
    repeat (5) begin adv(); chk_idle = 1'b1; fin(); end
    adv(); load(0, 6); load(2, 6); model('1); chk_ov = 1'b1; exp_ov = 1'b0; fin();
    ovp = 15'b001101111111111;
    busyp = 15'b011111111111111;
    for (int c = 0; c < 15; c++) begin
      adv(); chk_ov = 1'b1; exp_ov = ovp[c]; chk_busy = 1'b1; exp_busy = busyp[c]; fin();
    end
    adv(); load(1, 2); model('1); chk_ov = 1'b1; exp_ov = 1'b0; chk_busy = 1'b1; exp_busy = 1'b0; fin();
    ovp = 15'b000000000000011;
    busyp = 15'b000000000000111;
    for (int c = 0; c < 4; c++) begin
      adv(); chk_ov = 1'b1; exp_ov = ovp[c]; chk_busy = 1'b1; exp_busy = busyp[c]; fin();
    end
    adv(); for (int s = 0; s < N; s++) load(s, 6); model('1); fin();
    repeat (2) begin adv(); fin(); end
    adv(); out_back_pressure = 1'b1; chk_ov = 1'b1; exp_ov = 1'b1; fin();
    repeat (9) begin adv(); chk_ov = 1'b1; exp_ov = 1'b1; fin(); end
    adv(); out_back_pressure = 1'b0; fin();
    drain(1'b0);
    adv(); load(3, 4); expect_item(3, srcq[3][0]); mlast = 3; fin();
    adv(); fin();
    adv();
    load(0, 2); load(1, 2); load(2, 2);
    src_enable = 4'b0111;
    model(4'b0111);
    chk_ov = 1'b1; exp_ov = 1'b0; chk_busy = 1'b1; exp_busy = 1'b1;
    fin();
    drain(1'b0);
    adv(); srcq[3].delete(); src_enable = '1; fin();
    adv(); load(2, 4); expect_item(2, srcq[2][0]); fin();
    adv(); fin();
    adv(); resetN = 1'b0; chk_idle = 1'b1; fin();
    adv(); chk_idle = 1'b1; fin();
    adv(); resetN = 1'b1; load(0, 2); mlast = N - 1; model('1); fin();
    drain(1'b0);
    for (int r = 0; r < 8; r++) begin
      adv();
      for (int s = 0; s < N; s++) load(s, int'($urandom_range(0, 7)));
      src_enable = N'($urandom_range(1, (1 << N) - 1));
      model(src_enable);
      fin();
      drain(1'b1);
      adv();
      out_back_pressure = 1'b0;
      for (int s = 0; s < N; s++) srcq[s].delete();
      src_enable = '1;
      fin();
    end
    adv(); fin_chk = 1'b1; fin();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule

// File: doc/queue_drain_arbiter.md
# queue_drain_arbiter

Round-robin arbiter that drains up to NUM_SOURCES `shift_register_queue` output ports into one shared downstream port. Grants one source at a time for a burst of up to BURST_LEN items, then rotates priority. It drives each queue's `out_back_pressure` and uses the same valid/back-pressure handshake on both sides. A per-source enable mask lets software configuration exclude queues.

## Interface
Parameters:
- NUM_SOURCES, 4: number of queues arbitrated (2..16).
- DATA_WIDTH, 8: item width; must match the queues.
- BURST_LEN, 4: maximum items transferred per grant (1..255).
- IDX_WIDTH, derived: bits for a source index, clog2(NUM_SOURCES); not overridden.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clock  in  1  rising-edge clock.
- resetN  in  1  asynchronous active-low reset.
- src_data  in  NUM_SOURCES*DATA_WIDTH  queue front items, source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_valid  in  NUM_SOURCES  queue non-empty flags.
- src_back_pressure  out  NUM_SOURCES  1 = source i must not pop.
- src_enable  in  NUM_SOURCES  1 = source i may be granted.
- out_data  out  DATA_WIDTH  granted item.
- out_valid  out  1  out_data holds a valid item.
- out_back_pressure  in  1  1 = downstream not ready.
- grant_onehot  out  NUM_SOURCES  current grant; all zero in ARB_IDLE.
- busy  out  1  state is ARB_GRANT.

## Operation
- Effective request: req[i] = src_valid[i] & src_enable[i].
- A transfer happens at a rising edge when out_valid=1 and out_back_pressure=0. The granted queue pops on that same edge.
- Signals in ARB_GRANT:
  - out_valid = req[grant]
  - out_data = src_data[grant]
  - src_back_pressure[grant] = out_back_pressure | ~req[grant]
  - All other src_back_pressure bits = 1.
- Signals in ARB_IDLE:
  - All src_back_pressure bits = 1.
  - out_valid = 0 and out_data = 0.
- Priority pick: the first set bit of req, scanning from last_grant+1 upward and wrapping modulo NUM_SOURCES. last_grant has the lowest priority. If no bit is set, there is no pick.
- ARB_IDLE transitions:
  - If there is a pick: grant <= pick, beat_count <= 0, go to ARB_GRANT.
  - Otherwise stay in ARB_IDLE.
- ARB_GRANT, burst-end events:
  - A transfer with beat_count == BURST_LEN-1.
  - req[grant] == 0 in any cycle. This covers a queue going empty and an enable being cleared.
- ARB_GRANT, on a burst end:
  - last_grant <= grant.
  - Re-pick in the same cycle with req masked to exclude nothing.
  - If there is a pick: grant <= pick, beat_count <= 0, stay in ARB_GRANT.
  - Otherwise go to ARB_IDLE.
- ARB_GRANT, a transfer without a burst end: beat_count <= beat_count+1.
- ARB_GRANT, no transfer (out_back_pressure=1): grant and beat_count hold indefinitely. There is no timeout.
- beat_count is 8 bits. It never exceeds BURST_LEN-1 and never wraps.

## Timing
- Reset values:
  - state=ARB_IDLE, grant=0, last_grant=NUM_SOURCES-1 (so source 0 has first priority), beat_count=0.
  - Outputs: out_valid=0, out_data=0, src_back_pressure all 1, grant_onehot=0, busy=0.
- Request to first out_valid: 1 cycle. req is sampled in ARB_IDLE, and out_valid is high in the first ARB_GRANT cycle.
- Burst-length rotation: no bubble. The next source's item is on out_data in the cycle after the final transfer.
- Rotation caused by a source going empty: one bubble cycle, the ARB_GRANT cycle with req[grant]=0.
- Combinational paths:
  - out_back_pressure → src_back_pressure[grant]
  - src_valid/src_data → out_valid/out_data
  - There is no register on these paths, and no path from out_* back to out_*.
- Simultaneous events: if the last beat and the queue going empty coincide, they are treated as one burst end, and last_grant is updated once.
- Enable cleared mid-burst: takes effect in the same cycle, and no transfer occurs from that source.
- Reset asserted mid-burst: all state returns immediately to the reset values, and src_back_pressure goes to all 1. Queue contents are untouched.
- A single requesting source is re-granted back-to-back after each burst. There is no bubble when its req stays high.

## Structure
- Shared package `queue_arb_pkg`:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT}.
  - Constant function clog2 for IDX_WIDTH.
- Sub-module `rr_priority_picker`:
  - Combinational.
  - Inputs: req[NUM_SOURCES], last[IDX_WIDTH].
  - Outputs: pick[IDX_WIDTH], pick_valid.
  - Instantiated once and used by both FSM states.
- Top level holds the FSM, grant/last_grant/beat_count registers, and the output muxes.

## Test plan
- Reset, then req=4'b0000 for 5 cycles → out_valid=0, busy=0, src_back_pressure=4'b1111 throughout.
- Sources 0 and 2 each hold 6 items, BURST_LEN=4, out_back_pressure=0 → order 0,0,0,0,2,2,2,2,0,0,2,2, with no bubble at the burst-limit rotations.
- Source 1 only, 2 items → two transfers, one bubble cycle, then ARB_IDLE; grant_onehot=4'b0010 during the burst.
- All 4 sources full, out_back_pressure=1 for 10 cycles mid-burst after 2 beats → grant and out_data frozen, no pops; on release, exactly 2 more beats from the same source.
- src_enable[3] cleared mid-burst of source 3 → out_valid drops the same cycle, source 3 does not pop, grant moves to the next requester in order 0,1,2.
- resetN pulsed low during a burst from source 2 → outputs at reset values immediately; after release, source 0 is granted first if it is requesting.
